// File: rtl/regwrite_arbiter_pkg.sv
// Shared types and default sizing for the regfile write-port arbiter.
package regwrite_arbiter_pkg;

  localparam int unsigned XLEN        = 64;
  localparam int unsigned REG_AW      = 5;
  localparam int unsigned NLANES_DEF  = 4;
  localparam int unsigned NWPORTS_DEF = 2;
  localparam int unsigned QDEPTH_DEF  = 8;

  typedef struct packed {
    logic [REG_AW-1:0] adr;
    logic [XLEN-1:0]   data;
  } regwr_req_t;

endpackage

// File: rtl/regwrite_queue.sv
// Compacting ordered write buffer: merge-by-address, multi-dequeue at head,
// multi-enqueue at tail, registered count and pending-register mask.
module regwrite_queue
  import regwrite_arbiter_pkg::*;
#(
  parameter int unsigned NLANES = NLANES_DEF,
  parameter int unsigned QDEPTH = QDEPTH_DEF,
  localparam int unsigned CW    = $clog2(QDEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NLANES-1:0]        in_valid_i,
  input  regwr_req_t [NLANES-1:0]  in_req_i,
  output logic [NLANES-1:0]        merge_hit_c_o,
  output regwr_req_t [QDEPTH-1:0]  view_c_o,
  input  logic [CW-1:0]            deq_n_i,
  input  logic [CW-1:0]            enq_n_i,
  input  regwr_req_t [NLANES-1:0]  enq_req_i,
  output logic [CW-1:0]            count_o,
  output logic [31:0]              pending_o
);

  regwr_req_t [QDEPTH-1:0] q_q, q_d;
  logic [CW-1:0]           count_q, count_d;
  logic [31:0]             pend_q, pend_d;

  // Queue contents with this cycle's same-register updates folded in
  always_comb begin
    view_c_o      = q_q;
    merge_hit_c_o = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      for (int l = 0; l < NLANES; l++) begin
        if (i < int'(count_q) && in_valid_i[l] && in_req_i[l].adr == q_q[i].adr) begin
          view_c_o[i].data = in_req_i[l].data;
          merge_hit_c_o[l] = 1'b1;
        end
      end
    end
  end

  // Shift survivors down past the dequeued head, append new entries behind them
  always_comb begin
    q_d     = '0;
    pend_d  = '0;
    count_d = CW'(int'(count_q) - int'(deq_n_i) + int'(enq_n_i));
    for (int i = 0; i < QDEPTH; i++) begin
      for (int s = 0; s < QDEPTH; s++) begin
        if (s == i + int'(deq_n_i) && s < int'(count_q)) begin
          q_d[i] = view_c_o[s];
        end
      end
      for (int j = 0; j < NLANES; j++) begin
        if (i == int'(count_q) - int'(deq_n_i) + j && j < int'(enq_n_i)) begin
          q_d[i] = enq_req_i[j];
        end
      end
      pend_d[q_d[i].adr] = 1'b1;
    end
    // Empty slots are zeroed, so x0 never represents a real pending write
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= '0;
      count_q <= '0;
      pend_q  <= '0;
    end else begin
      q_q     <= q_d;
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

  assign count_o   = count_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/regwrite_arbiter.sv
// Shares NWPORTS regfile write ports among NLANES writeback lanes, buffering overflow.
// Optional perf counters enabled by `define REGWRITE_ARBITER_PERF_EN.
module regwrite_arbiter
  import regwrite_arbiter_pkg::*;
#(
  parameter int unsigned NLANES  = NLANES_DEF,
  parameter int unsigned NWPORTS = NWPORTS_DEF,
  parameter int unsigned QDEPTH  = QDEPTH_DEF,
  localparam int unsigned CW     = $clog2(QDEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NLANES-1:0]         LaneWe,
  input  logic [NLANES*5-1:0]       LaneAdr,
  input  logic [NLANES*XLEN-1:0]    LaneData,
  output logic [NWPORTS-1:0]        PortWe,
  output logic [NWPORTS*5-1:0]      PortAdr,
  output logic [NWPORTS*XLEN-1:0]   PortData,
  output logic                      WrStall,
  output logic [31:0]               PendingMask,
  output logic [31:0]               PerfStallCnt,
  output logic [CW-1:0]             PerfMaxOcc
);

  regwr_req_t [NLANES-1:0]  in_req;
  logic [NLANES-1:0]        in_valid;
  logic [NLANES-1:0]        merge_hit;
  logic [NLANES-1:0]        fresh;
  regwr_req_t [QDEPTH-1:0]  view;
  regwr_req_t [NWPORTS-1:0] port_req;
  logic [NWPORTS-1:0]       port_we;
  regwr_req_t [NLANES-1:0]  enq_req;
  logic [CW-1:0]            count, count_nxt, deq_n, enq_n;
  logic                     stall_q;
  int                       rank;

  // Drop x0 writes; within a bundle the youngest lane to a register wins
  always_comb begin
    in_req   = '0;
    in_valid = '0;
    for (int l = 0; l < NLANES; l++) begin
      in_req[l].adr  = LaneAdr[l*5 +: 5];
      in_req[l].data = LaneData[l*XLEN +: XLEN];
      in_valid[l]    = LaneWe[l] && (LaneAdr[l*5 +: 5] != 5'd0);
      for (int k = l + 1; k < NLANES; k++) begin
        if (LaneWe[k] && LaneAdr[k*5 +: 5] == LaneAdr[l*5 +: 5]) begin
          in_valid[l] = 1'b0;
        end
      end
    end
  end

  regwrite_queue #(
    .NLANES (NLANES),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk           (clk),
    .rst_n         (reset),
    .in_valid_i    (in_valid),
    .in_req_i      (in_req),
    .merge_hit_c_o (merge_hit),
    .view_c_o      (view),
    .deq_n_i       (deq_n),
    .enq_n_i       (enq_n),
    .enq_req_i     (enq_req),
    .count_o       (count),
    .pending_o     (PendingMask)
  );

  // Queue head first, then unmerged lanes in order; overflow goes to the tail
  always_comb begin
    fresh    = in_valid & ~merge_hit;
    deq_n    = (int'(count) < int'(NWPORTS)) ? count : CW'(NWPORTS);
    port_we  = '0;
    port_req = '0;
    enq_req  = '0;
    enq_n    = '0;
    rank     = int'(deq_n);
    for (int p = 0; p < NWPORTS; p++) begin
      if (p < int'(count)) begin
        port_we[p]  = 1'b1;
        port_req[p] = view[p];
      end
    end
    for (int l = 0; l < NLANES; l++) begin
      if (fresh[l]) begin
        for (int p = 0; p < NWPORTS; p++) begin
          if (p == rank) begin
            port_we[p]  = 1'b1;
            port_req[p] = in_req[l];
          end
        end
        for (int j = 0; j < NLANES; j++) begin
          if (j == rank - int'(NWPORTS)) begin
            enq_req[j] = in_req[l];
          end
        end
        if (rank >= int'(NWPORTS)) begin
          enq_n = enq_n + CW'(1);
        end
        rank = rank + 1;
      end
    end
    // Ports stay quiet while reset is held, even with lanes still driving
    if (!reset) begin
      port_we  = '0;
      port_req = '0;
    end
    count_nxt = CW'(int'(count) - int'(deq_n) + int'(enq_n));
  end

  always_comb begin
    PortWe   = '0;
    PortAdr  = '0;
    PortData = '0;
    for (int p = 0; p < NWPORTS; p++) begin
      PortWe[p]                 = port_we[p];
      PortAdr[p*5 +: 5]         = port_req[p].adr;
      PortData[p*XLEN +: XLEN]  = port_req[p].data;
    end
  end

  // Stall whenever the buffer could not absorb another full bundle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= 1'b0;
    end else begin
      stall_q <= (count_nxt > CW'(QDEPTH - NLANES));
    end
  end

  assign WrStall = stall_q;

`ifdef REGWRITE_ARBITER_PERF_EN
  logic [31:0]   stall_cnt_q;
  logic [CW-1:0] max_occ_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      max_occ_q   <= '0;
    end else begin
      if (stall_q && stall_cnt_q != 32'hFFFF_FFFF) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (count_nxt > max_occ_q) begin
        max_occ_q <= count_nxt;
      end
    end
  end

  assign PerfStallCnt = stall_cnt_q;
  assign PerfMaxOcc   = max_occ_q;
`else
  assign PerfStallCnt = '0;
  assign PerfMaxOcc   = '0;
`endif

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Self-checking bench for regwrite_arbiter: directed vector table, corner
// sequences and randomized traffic against a queue-based reference model.
module tb_regwrite_arbiter;
  import regwrite_arbiter_pkg::*;

  localparam int NL = 4;
  localparam int NP = 2;
  localparam int QD = 8;
  localparam int CW = $clog2(QD + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic [NL-1:0]     LaneWe;
  logic [NL*5-1:0]   LaneAdr;
  logic [NL*64-1:0]  LaneData;
  logic [NP-1:0]     PortWe;
  logic [NP*5-1:0]   PortAdr;
  logic [NP*64-1:0]  PortData;
  logic              WrStall;
  logic [31:0]       PendingMask;
  logic [31:0]       PerfStallCnt;
  logic [CW-1:0]     PerfMaxOcc;

  regwrite_arbiter #(.NLANES(NL), .NWPORTS(NP), .QDEPTH(QD)) dut (
    .clk          (clk),
    .reset        (reset),
    .LaneWe       (LaneWe),
    .LaneAdr      (LaneAdr),
    .LaneData     (LaneData),
    .PortWe       (PortWe),
    .PortAdr      (PortAdr),
    .PortData     (PortData),
    .WrStall      (WrStall),
    .PendingMask  (PendingMask),
    .PerfStallCnt (PerfStallCnt),
    .PerfMaxOcc   (PerfMaxOcc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int perf_stall = 0;
  int perf_max = 0;
  regwr_req_t mq[$];
  regwr_req_t mq_nxt[$];

  typedef struct {
    logic [3:0]   we;
    logic [19:0]  adr;
    logic [255:0] data;
    logic [1:0]   ewe;
    logic [9:0]   eadr;
    logic [127:0] edata;
    logic         estall;
    logic [31:0]  epend;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic [3:0] we,
                              input logic [4:0] a3, input logic [4:0] a2,
                              input logic [4:0] a1, input logic [4:0] a0,
                              input logic [63:0] d3, input logic [63:0] d2,
                              input logic [63:0] d1, input logic [63:0] d0,
                              input logic [1:0] ewe, input logic [4:0] p1a,
                              input logic [4:0] p0a, input logic [63:0] p1d,
                              input logic [63:0] p0d, input logic estall,
                              input logic [31:0] epend);
    vec_t v;
    v.we = we; v.adr = {a3, a2, a1, a0}; v.data = {d3, d2, d1, d0};
    v.ewe = ewe; v.eadr = {p1a, p0a}; v.edata = {p1d, p0d};
    v.estall = estall; v.epend = epend;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: merge into buffered copy, order = buffer then new lanes, issue first NP
  task automatic model_eval(output logic [1:0] ewe, output logic [9:0] eadr,
                            output logic [127:0] edata);
    regwr_req_t all[$];
    regwr_req_t inc[$];
    regwr_req_t e;
    logic [4:0] a;
    bit keep, merged;
    int n;
    ewe = '0; eadr = '0; edata = '0;
    all = mq;
    for (int l = 0; l < NL; l++) begin
      a = LaneAdr[l*5 +: 5];
      if (LaneWe[l] && a != 5'd0) begin
        keep = 1'b1;
        for (int k = l + 1; k < NL; k++)
          if (LaneWe[k] && LaneAdr[k*5 +: 5] == a) keep = 1'b0;
        if (keep) begin
          merged = 1'b0;
          foreach (all[i]) if (all[i].adr == a) begin
            all[i].data = LaneData[l*64 +: 64];
            merged = 1'b1;
          end
          if (!merged) begin
            e.adr = a; e.data = LaneData[l*64 +: 64];
            inc.push_back(e);
          end
        end
      end
    end
    foreach (inc[i]) all.push_back(inc[i]);
    if (!reset) all.delete();
    n = (all.size() < NP) ? all.size() : NP;
    for (int p = 0; p < n; p++) begin
      ewe[p] = 1'b1;
      eadr[p*5 +: 5] = all[p].adr;
      edata[p*64 +: 64] = all[p].data;
    end
    mq_nxt = all;
    repeat (n) void'(mq_nxt.pop_front());
  endtask

  task automatic apply(input logic [3:0] we, input logic [19:0] adr, input logic [255:0] data);
    logic [1:0] ewe; logic [9:0] eadr; logic [127:0] edata; logic [31:0] epend;
    LaneWe = we; LaneAdr = adr; LaneData = data;
    #1;
    model_eval(ewe, eadr, edata);
    epend = '0;
    foreach (mq[i]) epend[mq[i].adr] = 1'b1;
    chk("model_PortWe", PortWe, ewe);
    chk("model_PortAdr", PortAdr, eadr);
    chk("model_PortData", PortData, edata);
    chk("model_WrStall", WrStall, (mq.size() > QD - NL));
    chk("model_PendingMask", PendingMask, epend);
`ifdef REGWRITE_ARBITER_PERF_EN
    chk("model_PerfStallCnt", PerfStallCnt, perf_stall);
    chk("model_PerfMaxOcc", PerfMaxOcc, perf_max);
`else
    chk("model_PerfStallCnt", PerfStallCnt, 0);
    chk("model_PerfMaxOcc", PerfMaxOcc, 0);
`endif
    if (WrStall && |LaneWe) begin
      errors++;
      $display("FAIL upstream_hold: LaneWe=%0h while WrStall=1", LaneWe);
    end
    if (mq_nxt.size() > QD) begin
      errors++;
      $display("FAIL overflow: occupancy %0d exceeds %0d", mq_nxt.size(), QD);
    end
  endtask

  task automatic advance();
    bit stall_now;
    stall_now = (mq.size() > QD - NL);
    @(posedge clk);
    mq = mq_nxt;
    if (stall_now) perf_stall++;
    if (mq.size() > perf_max) perf_max = mq.size();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rwe;
    logic [19:0] radr;
    logic [255:0] rdata;
    int guard;

    tbl[0]  = mk(4'b0011, 0, 0, 6, 5, 0, 0, 64'h22, 64'h11, 2'b11, 6, 5, 64'h22, 64'h11, 0, 32'h0);
    tbl[1]  = mk(4'b1111, 4, 3, 2, 1, 4, 3, 2, 1, 2'b11, 2, 1, 2, 1, 0, 32'h0);
    tbl[2]  = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4, 3, 4, 3, 0, 32'h18);
    tbl[3]  = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 32'h0);
    tbl[4]  = mk(4'b1011, 7, 0, 7, 0, 64'hB, 0, 64'hA, 64'h55, 2'b01, 0, 7, 0, 64'hB, 0, 32'h0);
    tbl[5]  = mk(4'b1111, 13, 12, 11, 10, 64'h103, 64'h102, 64'h101, 64'h100,
                 2'b11, 11, 10, 64'h101, 64'h100, 0, 32'h0);
    tbl[6]  = mk(4'b0111, 0, 9, 15, 14, 0, 64'h1, 64'h105, 64'h104,
                 2'b11, 13, 12, 64'h103, 64'h102, 0, 32'h3000);
    tbl[7]  = mk(4'b0001, 0, 0, 0, 9, 0, 0, 0, 64'h2, 2'b11, 15, 14, 64'h105, 64'h104, 0, 32'hC200);
    tbl[8]  = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 9, 0, 64'h2, 0, 32'h200);
    tbl[9]  = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 32'h0);
    tbl[10] = mk(4'b1111, 19, 18, 17, 16, 64'h219, 64'h218, 64'h217, 64'h216,
                 2'b11, 17, 16, 64'h217, 64'h216, 0, 32'h0);
    tbl[11] = mk(4'b1111, 23, 22, 21, 20, 64'h223, 64'h222, 64'h221, 64'h220,
                 2'b11, 19, 18, 64'h219, 64'h218, 0, 32'h000C_0000);
    tbl[12] = mk(4'b1111, 27, 26, 25, 24, 64'h227, 64'h226, 64'h225, 64'h224,
                 2'b11, 21, 20, 64'h221, 64'h220, 0, 32'h00F0_0000);
    tbl[13] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 23, 22, 64'h223, 64'h222, 1, 32'h0FC0_0000);
    tbl[14] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 25, 24, 64'h225, 64'h224, 0, 32'h0F00_0000);
    tbl[15] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 27, 26, 64'h227, 64'h226, 0, 32'h0C00_0000);
    tbl[16] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 32'h0);

    reset = 1'b0; LaneWe = '0; LaneAdr = '0; LaneData = '0;
    @(negedge clk); #1;
    chk("rst_PortWe", PortWe, 0);
    chk("rst_PortAdr", PortAdr, 0);
    chk("rst_PortData", PortData, 0);
    chk("rst_WrStall", WrStall, 0);
    chk("rst_PendingMask", PendingMask, 0);
    chk("rst_PerfStallCnt", PerfStallCnt, 0);
    chk("rst_PerfMaxOcc", PerfMaxOcc, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].we, tbl[i].adr, tbl[i].data);
      chk($sformatf("vec%0d_PortWe", i), PortWe, tbl[i].ewe);
      chk($sformatf("vec%0d_PortAdr", i), PortAdr, tbl[i].eadr);
      chk($sformatf("vec%0d_PortData", i), PortData, tbl[i].edata);
      chk($sformatf("vec%0d_WrStall", i), WrStall, tbl[i].estall);
      chk($sformatf("vec%0d_PendingMask", i), PendingMask, tbl[i].epend);
      advance();
    end
`ifdef REGWRITE_ARBITER_PERF_EN
    chk("burst_PerfStallCnt", PerfStallCnt, 1);
    chk("burst_PerfMaxOcc", PerfMaxOcc, 6);
`endif

    // Randomized traffic over a small register range to provoke collisions and merges
    for (int c = 0; c < 400; c++) begin
      rwe = (mq.size() > QD - NL) ? 4'b0000 : 4'($urandom);
      for (int l = 0; l < NL; l++) radr[l*5 +: 5] = 5'($urandom_range(0, 7));
      for (int w = 0; w < 8; w++) rdata[w*32 +: 32] = $urandom;
      apply(rwe, radr, rdata);
      advance();
    end

    guard = 0;
    while (mq.size() != 0 && guard < 20) begin
      apply(4'b0000, 20'd0, 256'd0);
      advance();
      guard++;
    end
    chk("drain_bounded", (mq.size() == 0), 1);

    // Build occupancy 5, then pull reset with lanes still active
    apply(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {64'h4, 64'h3, 64'h2, 64'h1});
    advance();
    apply(4'b1111, {5'd8, 5'd7, 5'd6, 5'd5}, {64'h8, 64'h7, 64'h6, 64'h5});
    advance();
    apply(4'b0111, {5'd0, 5'd11, 5'd10, 5'd9}, {64'h0, 64'hB, 64'hA, 64'h9});
    advance();
    chk("pre_rst_WrStall", WrStall, 1);
    LaneWe = 4'b1111; LaneAdr = {5'd15, 5'd14, 5'd13, 5'd12}; LaneData = {4{64'hDEAD}};
    #1 reset = 1'b0;
    #1;
    chk("midrst_PortWe", PortWe, 0);
    chk("midrst_PortAdr", PortAdr, 0);
    chk("midrst_PortData", PortData, 0);
    chk("midrst_WrStall", WrStall, 0);
    chk("midrst_PendingMask", PendingMask, 0);
    chk("midrst_PerfStallCnt", PerfStallCnt, 0);
    chk("midrst_PerfMaxOcc", PerfMaxOcc, 0);
    mq.delete();
    perf_stall = 0;
    perf_max = 0;
    @(posedge clk);
    @(negedge clk);
    LaneWe = '0;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      apply(4'b0000, 20'd0, 256'd0);
      chk($sformatf("postrst%0d_PortWe", c), PortWe, 0);
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regwrite_arbiter.md
Name: regwrite_arbiter

Overview:
- Shares a register file with NWPORTS write ports among NLANES VLIW integer lanes.
- Each lane's writeback stage presents its regfile write request (we3/a3/wd3 relay) every cycle.
- The arbiter issues up to NWPORTS writes per cycle and buffers the excess in an ordered queue, merging same-register updates.
- It stalls writeback when the buffer cannot absorb a full bundle, and exports a pending-register mask so the hazard unit can stall reads of registers whose writes are still buffered.

Parameters:
- XLEN, 64, data width
- NLANES, 4, number of requesting lanes; lane index = program order within a bundle
- NWPORTS, 2, regfile write ports
- QDEPTH, 8, buffer entries; must be >= NLANES + NWPORTS

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset
- LaneWe  input  NLANES  per-lane write enable (RegWriteW of each lane)
- LaneAdr  input  NLANES*5  per-lane destination register
- LaneData  input  NLANES*XLEN  per-lane write data (ResultW of each lane)
- PortWe  output  NWPORTS  regfile write enables
- PortAdr  output  NWPORTS*5  regfile write addresses
- PortData  output  NWPORTS*XLEN  regfile write data
- WrStall  output  1  writeback stall request to hazard unit
- PendingMask  output  32  bit r set = write to xr buffered (not yet issued)
- PerfStallCnt  output  32  stall-cycle counter (see Optional Feature)
- PerfMaxOcc  output  $clog2(QDEPTH+1)  occupancy high-water mark

Behaviour:
- Reset (asynchronous, active-low): queue empty, count=0, PortWe=0, PortAdr=0, PortData=0, WrStall=0, PendingMask=0, perf outputs=0.
- Incoming filter, combinational, same cycle:
  - A request with LaneAdr=0 is dropped.
  - If several lanes target the same rd, only the highest-index lane survives.
- Merge:
  - A surviving incoming request whose rd matches a queued entry overwrites that entry's data in place.
  - The entry keeps its queue position; the request is then consumed.
  - A rd therefore never appears twice in the queue.
- Issue order: queue entries oldest-first, then unmerged incoming requests in ascending lane order; the first NWPORTS are issued.
- Latency:
  - An incoming request issued in its arrival cycle drives the ports combinationally (zero latency).
  - A queued entry is issued no earlier than the cycle after enqueue.
- Port assignment: the i-th issued write goes to port i; unused ports have PortWe=0 and PortAdr/PortData=0.
- Enqueue: unissued incoming requests are appended at the tail in lane order at the clock edge. The queue compacts on dequeue (no wrap pointers).
- Occupancy: count_next = count + enqueued - dequeued_from_queue.
- WrStall:
  - WrStall = (count > QDEPTH - NLANES - NWPORTS + NWPORTS), i.e. count > QDEPTH - NLANES, driven from registered count only.
  - While WrStall=1, upstream holds every LaneWe=0. Arbiter behaviour for requests violating this is undefined; the bench asserts on it.
  - An enqueue that would exceed QDEPTH is an assertion failure.
- PendingMask: one-hot OR of registered queue addresses; updates one cycle after enqueue/dequeue.
- Empty queue with no requests: all PortWe=0, count holds.
- Full queue drain: WrStall deasserts in the cycle after count drops to <= QDEPTH-NLANES.
- Reset mid-operation: buffered writes are discarded with no port activity.

Optional Feature:
- Macro: REGWRITE_ARBITER_PERF_EN.
- Defined:
  - PerfStallCnt increments (saturating at 2^32-1) on each cycle WrStall=1.
  - PerfMaxOcc tracks the maximum count since reset.
  - Both are registered and cleared by reset.
- Undefined: both outputs are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package cvw gains typedef regwr_req_t {logic [4:0] adr; logic [XLEN-1:0] data;}, parameterised via the cvw_t XLEN.
- Shared package cvw gains constants for the default NLANES and NWPORTS.
- One sub-module, regwrite_queue: compacting ordered buffer holding regwr_req_t entries, with merge-by-address, multi-dequeue from the head, multi-enqueue at the tail, and count and PendingMask outputs.
- Filter, issue selection and perf counters stay in regwrite_arbiter.

Test Plan:
- Reset low mid-traffic with count=5: all outputs 0 immediately; after release the queue is empty and no stale writes are issued.
- Lanes 0,1 write x5=0x11, x6=0x22, lanes 2,3 idle, queue empty: PortWe=2'b11, PortAdr={6,5}, same cycle; count stays 0.
- All four lanes write x1..x4=1..4: ports issue x1,x2; x3,x4 enqueued (count=2). Next cycle with no input: x3,x4 issued; PendingMask=0x18 then 0.
- Lanes 1 and 3 both write x7 (0xA, 0xB), lane 0 writes x0: only x7=0xB issued; x0 is never on a port.
- x9=0x1 queued behind two entries; new lane write x9=0x2 arrives: the entry merges in place, count unchanged, and x9 is later issued once with 0x2.
- Four-lane bursts for 3 cycles: count reaches 6 and WrStall=1 with count>4. With REGWRITE_ARBITER_PERF_EN, PerfStallCnt counts the stall cycles and PerfMaxOcc=6; WrStall clears once count<=4.
